// File: rtl/reg_file_bypass_pkg.sv
// rtl/reg_file_bypass_pkg.sv - shared register file constants for the core datapath
package reg_file_bypass_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/reg_file_bypass_reg_16bit.sv
// rtl/reg_file_bypass_reg_16bit.sv - one general register with write enable and sync clear
module reg_16bit
  import reg_file_bypass_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Clear takes priority so a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_bypass.sv
// rtl/reg_file_bypass.sv - 16x16 register file, two async read ports, one write port with bypass
module reg_file_bypass
  import reg_file_bypass_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] SrcReg1,
  input  logic [ADDR_W-1:0] SrcReg2,
  input  logic [ADDR_W-1:0] DstReg,
  input  logic              WriteReg,
  input  logic [DATA_W-1:0] DstData,
  output logic [DATA_W-1:0] SrcData1,
  output logic [DATA_W-1:0] SrcData2
);

  logic              wr_valid;
  logic [NUM_REGS-1:0] wr_sel;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              byp1;
  logic              byp2;

  assign wr_valid = WriteReg && (DstReg != ZERO_REG);

  always_comb begin
    wr_sel = '0;
    if (wr_valid) begin
      wr_sel[DstReg] = 1'b1;
    end
  end

  assign regs[0] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    reg_16bit u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_sel[i]),
      .d     (DstData),
      .q     (regs[i])
    );
  end

  assign rd_data1 = regs[SrcReg1];
  assign rd_data2 = regs[SrcReg2];

  // Bypass is a final 2:1 after the read mux; suppressed while reset is asserted.
  assign byp1 = rst_n && wr_valid && (SrcReg1 == DstReg);
  assign byp2 = rst_n && wr_valid && (SrcReg2 == DstReg);

  assign SrcData1 = byp1 ? DstData : rd_data1;
  assign SrcData2 = byp2 ? DstData : rd_data2;

endmodule

// File: tb/tb_reg_file_bypass.sv
// tb/tb_reg_file_bypass.sv - directed and model-checked bench for reg_file_bypass
module tb_reg_file_bypass;

  logic        clk;
  logic        rst_n;
  logic [3:0]  SrcReg1;
  logic [3:0]  SrcReg2;
  logic [3:0]  DstReg;
  logic        WriteReg;
  logic [15:0] DstData;
  logic [15:0] SrcData1;
  logic [15:0] SrcData2;

  int vectors;
  int miscompares;

  reg_file_bypass dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SrcReg1  (SrcReg1),
    .SrcReg2  (SrcReg2),
    .DstReg   (DstReg),
    .WriteReg (WriteReg),
    .DstData  (DstData),
    .SrcData1 (SrcData1),
    .SrcData2 (SrcData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic write_reg(input logic [3:0] addr, input logic [15:0] data);
    @(negedge clk);
    WriteReg = 1'b1;
    DstReg   = addr;
    DstData  = data;
    @(posedge clk);
    #1;
    WriteReg = 1'b0;
  endtask

  task automatic test_reset;
    for (int a = 1; a < 16; a++) write_reg(a[3:0], 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      SrcReg1 = a[3:0];
      SrcReg2 = a[3:0];
      #1;
      vectors++;
      if (SrcData1 !== 16'h0000) begin
        miscompares++;
        $display("FAIL reset_p1 r%0d: got %h expected 0000", a, SrcData1);
      end
      vectors++;
      if (SrcData2 !== 16'h0000) begin
        miscompares++;
        $display("FAIL reset_p2 r%0d: got %h expected 0000", a, SrcData2);
      end
    end
  endtask

  task automatic test_r0;
    @(negedge clk);
    WriteReg = 1'b1;
    DstReg   = 4'd0;
    DstData  = 16'hBEEF;
    SrcReg1  = 4'd0;
    SrcReg2  = 4'd0;
    #1;
    vectors++;
    if (SrcData1 !== 16'h0000) begin
      miscompares++;
      $display("FAIL r0_during_write: got %h expected 0000", SrcData1);
    end
    @(posedge clk);
    #1;
    WriteReg = 1'b0;
    #1;
    vectors++;
    if (SrcData1 !== 16'h0000) begin
      miscompares++;
      $display("FAIL r0_after_write: got %h expected 0000", SrcData1);
    end
  endtask

  task automatic test_write_read;
    write_reg(4'd5, 16'h1234);
    SrcReg1 = 4'd5;
    SrcReg2 = 4'd5;
    #1;
    vectors++;
    if (SrcData1 !== 16'h1234) begin
      miscompares++;
      $display("FAIL wr_rd_p1: got %h expected 1234", SrcData1);
    end
    vectors++;
    if (SrcData2 !== 16'h1234) begin
      miscompares++;
      $display("FAIL wr_rd_p2: got %h expected 1234", SrcData2);
    end
    SrcReg1 = 4'd4;
    SrcReg2 = 4'd6;
    #1;
    vectors++;
    if (SrcData1 !== 16'h0000) begin
      miscompares++;
      $display("FAIL wr_rd_r4: got %h expected 0000", SrcData1);
    end
    vectors++;
    if (SrcData2 !== 16'h0000) begin
      miscompares++;
      $display("FAIL wr_rd_r6: got %h expected 0000", SrcData2);
    end
  endtask

  task automatic test_bypass;
    write_reg(4'd7, 16'h00AA);
    write_reg(4'd3, 16'h0033);
    @(negedge clk);
    WriteReg = 1'b1;
    DstReg   = 4'd7;
    DstData  = 16'h5555;
    SrcReg1  = 4'd7;
    SrcReg2  = 4'd3;
    #1;
    vectors++;
    if (SrcData1 !== 16'h5555) begin
      miscompares++;
      $display("FAIL bypass_p1: got %h expected 5555", SrcData1);
    end
    vectors++;
    if (SrcData2 !== 16'h0033) begin
      miscompares++;
      $display("FAIL bypass_p2_other: got %h expected 0033", SrcData2);
    end
    SrcReg2 = 4'd7;
    #1;
    vectors++;
    if (SrcData2 !== 16'h5555) begin
      miscompares++;
      $display("FAIL bypass_p2_same: got %h expected 5555", SrcData2);
    end
    @(posedge clk);
    #1;
    WriteReg = 1'b0;
    DstData  = 16'h0000;
    #1;
    vectors++;
    if (SrcData1 !== 16'h5555) begin
      miscompares++;
      $display("FAIL bypass_stored: got %h expected 5555", SrcData1);
    end
  endtask

  task automatic test_reset_collision;
    write_reg(4'd9, 16'h1111);
    @(negedge clk);
    rst_n    = 1'b0;
    WriteReg = 1'b1;
    DstReg   = 4'd9;
    DstData  = 16'h7777;
    SrcReg1  = 4'd9;
    #1;
    vectors++;
    if (SrcData1 !== 16'h1111) begin
      miscompares++;
      $display("FAIL collide_no_bypass: got %h expected 1111", SrcData1);
    end
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    WriteReg = 1'b0;
    #1;
    vectors++;
    if (SrcData1 !== 16'h0000) begin
      miscompares++;
      $display("FAIL collide_cleared: got %h expected 0000", SrcData1);
    end
    write_reg(4'd9, 16'h2222);
    #1;
    vectors++;
    if (SrcData1 !== 16'h2222) begin
      miscompares++;
      $display("FAIL collide_first_write: got %h expected 2222", SrcData1);
    end
  endtask

  task automatic test_random;
    logic [15:0] model [16];
    logic [15:0] exp1;
    logic [15:0] exp2;
    bit          wv;
    // Start from a known state so the model matches storage.
    @(negedge clk);
    rst_n = 1'b0;
    WriteReg = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      rst_n    = ($urandom_range(0, 49) != 0);
      WriteReg = $urandom_range(0, 3) != 0;
      DstReg   = 4'($urandom_range(0, 15));
      DstData  = 16'($urandom);
      SrcReg1  = ($urandom_range(0, 3) == 0) ? DstReg : 4'($urandom_range(0, 15));
      SrcReg2  = ($urandom_range(0, 3) == 0) ? DstReg : 4'($urandom_range(0, 15));
      wv   = rst_n && WriteReg && (DstReg != 4'd0);
      exp1 = (wv && SrcReg1 == DstReg) ? DstData : model[SrcReg1];
      exp2 = (wv && SrcReg2 == DstReg) ? DstData : model[SrcReg2];
      #1;
      vectors++;
      if (SrcData1 !== exp1) begin
        miscompares++;
        $display("FAIL rand_p1 cyc%0d r%0d: got %h expected %h", n, SrcReg1, SrcData1, exp1);
      end
      vectors++;
      if (SrcData2 !== exp2) begin
        miscompares++;
        $display("FAIL rand_p2 cyc%0d r%0d: got %h expected %h", n, SrcReg2, SrcData2, exp2);
      end
      @(posedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
      end else if (wv) begin
        model[DstReg] = DstData;
      end
    end
    @(negedge clk);
    rst_n    = 1'b1;
    WriteReg = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n    = 1'b0;
    WriteReg = 1'b0;
    DstReg   = 4'd0;
    DstData  = 16'h0000;
    SrcReg1  = 4'd0;
    SrcReg2  = 4'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_r0();
    test_write_read();
    test_bypass();
    test_reset_collision();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
